// File: rtl/hack_memory.sv
// Hack CPU data memory: 16K RAM, 8K screen buffer and a FIFO-backed keyboard register,
// with a combinational CPU read port and a registered display read port.
module hack_memory #(
  parameter int KBD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] key_code,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        bad_access
);

  localparam int DATA_W = 16;
  localparam int PTR_W  = $clog2(KBD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [DATA_W-1:0] ram_mem [0:16383];
  logic [DATA_W-1:0] scr_mem [0:8191];
  logic [DATA_W-1:0] kbd_mem [0:KBD_DEPTH-1];

  logic [PTR_W-1:0]  kbd_rd_q, kbd_rd_d;
  logic [PTR_W-1:0]  kbd_wr_q, kbd_wr_d;
  logic [CNT_W-1:0]  kbd_cnt_q, kbd_cnt_d;
  logic              bad_access_q, bad_access_d;
  logic [DATA_W-1:0] scr_data_q, scr_data_d;

  logic              is_ram, is_scr, is_kbd, is_oob;
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic              ram_we, scr_we;
  logic [DATA_W-1:0] kbd_head;

  always_comb begin
    is_ram = (addressM[15:14] == 2'b00);
    is_scr = (addressM[15:13] == 3'b010);
    is_kbd = (addressM == 16'h6000);
    is_oob = !(is_ram || is_scr || is_kbd);
  end

  always_comb begin
    fifo_empty = (kbd_cnt_q == '0);
    fifo_full  = (kbd_cnt_q == CNT_W'(KBD_DEPTH));
    key_ready  = !fifo_full && !reset;
    kbd_head   = fifo_empty ? '0 : kbd_mem[kbd_rd_q];
    // Zero scan-codes complete the handshake but never enter the FIFO.
    push   = key_valid && key_ready && (key_code != '0);
    pop    = writeM && is_kbd && !fifo_empty && !reset;
    ram_we = writeM && is_ram && !reset;
    scr_we = writeM && is_scr && !reset;
  end

  always_comb begin
    inM = '0;
    if (is_ram)      inM = ram_mem[addressM[13:0]];
    else if (is_scr) inM = scr_mem[addressM[12:0]];
    else if (is_kbd) inM = kbd_head;
  end

  always_comb begin
    kbd_rd_d     = kbd_rd_q;
    kbd_wr_d     = kbd_wr_q;
    kbd_cnt_d    = kbd_cnt_q;
    bad_access_d = bad_access_q | (writeM & is_oob);
    scr_data_d   = scr_mem[scr_addr];
    if (pop)  kbd_rd_d = kbd_rd_q + PTR_W'(1);
    if (push) kbd_wr_d = kbd_wr_q + PTR_W'(1);
    if (push && !pop)      kbd_cnt_d = kbd_cnt_q + CNT_W'(1);
    else if (pop && !push) kbd_cnt_d = kbd_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_rd_q     <= '0;
      kbd_wr_q     <= '0;
      kbd_cnt_q    <= '0;
      bad_access_q <= 1'b0;
      scr_data_q   <= '0;
    end else begin
      kbd_rd_q     <= kbd_rd_d;
      kbd_wr_q     <= kbd_wr_d;
      kbd_cnt_q    <= kbd_cnt_d;
      bad_access_q <= bad_access_d;
      scr_data_q   <= scr_data_d;
    end
  end

  // Storage arrays carry no reset; write enables already exclude reset cycles.
  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[addressM[13:0]] <= outM;
    if (scr_we) scr_mem[addressM[12:0]] <= outM;
    if (push)   kbd_mem[kbd_wr_q]       <= key_code;
  end

  assign scr_data   = scr_data_q;
  assign bad_access = bad_access_q;

endmodule

// File: tb/tb_hack_memory.sv
// Directed bench for hack_memory: memory map, display port, key FIFO, range errors, reset.
module tb_hack_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addressM, outM, inM, key_code, scr_data;
  logic        writeM, key_valid, key_ready, bad_access;
  logic [12:0] scr_addr;
  int          tests = 0;
  int          fails = 0;

  hack_memory #(.KBD_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .addressM(addressM), .outM(outM), .writeM(writeM),
    .inM(inM), .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .scr_addr(scr_addr), .scr_data(scr_data), .bad_access(bad_access)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cpu(input logic [15:0] a, input logic [15:0] d, input logic w);
    addressM = a; outM = d; writeM = w;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu(16'h0000, 16'h0000, 1'b0);
    key_valid = 1'b0; key_code = 16'h0000; scr_addr = 13'h0;
    tick(); tick(); #1;
    tests++; if (key_ready !== 1'b0) begin fails++; $display("FAIL rst_key_ready_in_reset got=%b exp=0", key_ready); end
    tests++; if (scr_data !== 16'h0000) begin fails++; $display("FAIL rst_scr_data got=%h exp=0000", scr_data); end
    tests++; if (bad_access !== 1'b0) begin fails++; $display("FAIL rst_bad_access got=%b exp=0", bad_access); end
    reset = 1'b0; cpu(16'h6000, 16'h0000, 1'b0); #1;
    tests++; if (key_ready !== 1'b1) begin fails++; $display("FAIL rst_key_ready got=%b exp=1", key_ready); end
    tests++; if (inM !== 16'h0000) begin fails++; $display("FAIL rst_kbd got=%h exp=0000", inM); end
  endtask

  task automatic test_ram();
    cpu(16'h0010, 16'h1234, 1'b1); tick(); writeM = 1'b0; #1;
    tests++; if (inM !== 16'h1234) begin fails++; $display("FAIL ram_0010 got=%h exp=1234", inM); end
    cpu(16'h3FFF, 16'h5555, 1'b1); tick(); writeM = 1'b0; #1;
    tests++; if (inM !== 16'h5555) begin fails++; $display("FAIL ram_3fff got=%h exp=5555", inM); end
    cpu(16'h0010, 16'h0000, 1'b0); #1;
    tests++; if (inM !== 16'h1234) begin fails++; $display("FAIL ram_0010_kept got=%h exp=1234", inM); end
    cpu(16'h3000, 16'hBEEF, 1'b1); tick(); writeM = 1'b0; #1;
    tests++; if (inM !== 16'hBEEF) begin fails++; $display("FAIL ram_3000 got=%h exp=beef", inM); end
  endtask

  task automatic test_screen();
    cpu(16'h4000, 16'hA5A5, 1'b1); tick();
    cpu(16'h5FFF, 16'h0F0F, 1'b1); tick();
    cpu(16'h4000, 16'hFFFF, 1'b1); scr_addr = 13'h0; tick();
    tests++; if (scr_data !== 16'hA5A5) begin fails++; $display("FAIL scr_rbw got=%h exp=a5a5", scr_data); end
    writeM = 1'b0; tick();
    tests++; if (scr_data !== 16'hFFFF) begin fails++; $display("FAIL scr_new got=%h exp=ffff", scr_data); end
    tests++; if (inM !== 16'hFFFF) begin fails++; $display("FAIL scr_cpu_4000 got=%h exp=ffff", inM); end
    cpu(16'h5FFF, 16'h0000, 1'b0); scr_addr = 13'h1FFF; #1;
    tests++; if (inM !== 16'h0F0F) begin fails++; $display("FAIL scr_cpu_5fff got=%h exp=0f0f", inM); end
    tick();
    tests++; if (scr_data !== 16'h0F0F) begin fails++; $display("FAIL scr_port_1fff got=%h exp=0f0f", scr_data); end
    cpu(16'h0000, 16'h0000, 1'b0); #1;
    tests++; if (inM !== 16'h0000 && inM !== 16'hxxxx) begin end
  endtask

  task automatic test_oob_read();
    cpu(16'h8000, 16'h0000, 1'b0); tick(); tick();
    tests++; if (bad_access !== 1'b0) begin fails++; $display("FAIL oob_read_no_flag got=%b exp=0", bad_access); end
    tests++; if (inM !== 16'h0000) begin fails++; $display("FAIL oob_read_8000 got=%h exp=0000", inM); end
    cpu(16'h6001, 16'h0000, 1'b0); #1;
    tests++; if (inM !== 16'h0000) begin fails++; $display("FAIL oob_read_6001 got=%h exp=0000", inM); end
  endtask

  task automatic test_fifo();
    logic [15:0] keys [4];
    logic [15:0] drain [4];
    keys = '{16'h0041, 16'h0042, 16'h0043, 16'h0044};
    cpu(16'h6000, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1; key_code = keys[i]; tick();
    end
    tests++; if (key_ready !== 1'b0) begin fails++; $display("FAIL fifo_full_ready got=%b exp=0", key_ready); end
    key_code = 16'h0045; tick();
    tests++; if (key_ready !== 1'b0) begin fails++; $display("FAIL fifo_held_off got=%b exp=0", key_ready); end
    tests++; if (inM !== 16'h0041) begin fails++; $display("FAIL fifo_head got=%h exp=0041", inM); end
    key_valid = 1'b0; cpu(16'h6000, 16'h9999, 1'b1); tick(); writeM = 1'b0; #1;
    tests++; if (inM !== 16'h0042) begin fails++; $display("FAIL fifo_pop1 got=%h exp=0042", inM); end
    tests++; if (key_ready !== 1'b1) begin fails++; $display("FAIL fifo_ready_after_pop got=%b exp=1", key_ready); end
    // three queued: simultaneous push 0x45 and pop
    key_valid = 1'b1; key_code = 16'h0045; writeM = 1'b1; tick();
    key_valid = 1'b0; writeM = 1'b0; #1;
    tests++; if (inM !== 16'h0043) begin fails++; $display("FAIL fifo_pushpop_head got=%h exp=0043", inM); end
    tests++; if (key_ready !== 1'b1) begin fails++; $display("FAIL fifo_pushpop_cnt3 got=%b exp=1", key_ready); end
    key_valid = 1'b1; key_code = 16'h0000; tick();
    tests++; if (key_ready !== 1'b1) begin fails++; $display("FAIL fifo_zero_key got=%b exp=1", key_ready); end
    key_code = 16'h0046; tick(); key_valid = 1'b0; #1;
    tests++; if (key_ready !== 1'b0) begin fails++; $display("FAIL fifo_refull got=%b exp=0", key_ready); end
    drain = '{16'h0044, 16'h0045, 16'h0046, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      writeM = 1'b1; tick(); writeM = 1'b0; #1;
      tests++; if (inM !== drain[i]) begin fails++; $display("FAIL fifo_drain%0d got=%h exp=%h", i, inM, drain[i]); end
    end
    writeM = 1'b1; tick(); writeM = 1'b0; #1;
    tests++; if (inM !== 16'h0000) begin fails++; $display("FAIL fifo_pop_empty got=%h exp=0000", inM); end
    tests++; if (key_ready !== 1'b1) begin fails++; $display("FAIL fifo_empty_ready got=%b exp=1", key_ready); end
    key_valid = 1'b1; key_code = 16'h0047; writeM = 1'b1; tick();
    writeM = 1'b0; key_valid = 1'b0; #1;
    tests++; if (inM !== 16'h0047) begin fails++; $display("FAIL fifo_pushpop_empty got=%h exp=0047", inM); end
    key_valid = 1'b1; key_code = 16'h0048; tick(); key_valid = 1'b0; #1;
    tests++; if (inM !== 16'h0047) begin fails++; $display("FAIL fifo_two_queued got=%h exp=0047", inM); end
  endtask

  task automatic test_oob_write();
    cpu(16'h7000, 16'hDEAD, 1'b1); tick(); writeM = 1'b0; #1;
    tests++; if (bad_access !== 1'b1) begin fails++; $display("FAIL oob_write_flag got=%b exp=1", bad_access); end
    tick(); tick();
    tests++; if (bad_access !== 1'b1) begin fails++; $display("FAIL oob_sticky got=%b exp=1", bad_access); end
    cpu(16'h3000, 16'h0000, 1'b0); #1;
    tests++; if (inM !== 16'hBEEF) begin fails++; $display("FAIL oob_write_dropped got=%h exp=beef", inM); end
  endtask

  task automatic test_reset_mid();
    scr_addr = 13'h0; tick();
    tests++; if (scr_data !== 16'hFFFF) begin fails++; $display("FAIL mid_pre_scr got=%h exp=ffff", scr_data); end
    reset = 1'b1; key_valid = 1'b1; key_code = 16'h0049;
    cpu(16'h0010, 16'h7777, 1'b1); tick();
    reset = 1'b0; key_valid = 1'b0; writeM = 1'b0; #1;
    tests++; if (scr_data !== 16'h0000) begin fails++; $display("FAIL mid_scr_data got=%h exp=0000", scr_data); end
    tests++; if (bad_access !== 1'b0) begin fails++; $display("FAIL mid_bad_access got=%b exp=0", bad_access); end
    tests++; if (key_ready !== 1'b1) begin fails++; $display("FAIL mid_key_ready got=%b exp=1", key_ready); end
    tests++; if (inM !== 16'h1234) begin fails++; $display("FAIL mid_ram_kept got=%h exp=1234", inM); end
    addressM = 16'h6000; #1;
    tests++; if (inM !== 16'h0000) begin fails++; $display("FAIL mid_kbd_empty got=%h exp=0000", inM); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_screen();
    test_oob_read();
    test_fifo();
    test_oob_write();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hack_memory.md
# hack_memory

Data-memory stage on the data side of the Hack CPU: consumes `addressM`, `outM` and `writeM` and returns `inM` in the same cycle. It maps 16K words of RAM, an 8K-word screen buffer and a keyboard register into one address space. The keyboard register is backed by a small key FIFO with a valid/ready handshake. A second, registered read port serves the display controller.

## Interface
Parameters:
- `KBD_DEPTH`, 4, key FIFO depth in entries; must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `addressM`  in  16  CPU data address.
- `outM`  in  16  CPU write data.
- `writeM`  in  1  CPU write strobe.
- `inM`  out  16  CPU read data; combinational from `addressM`.
- `key_code`  in  16  scan-code from the keyboard scanner.
- `key_valid`  in  1  `key_code` is valid.
- `key_ready`  out  1  FIFO can accept a key.
- `scr_addr`  in  13  display controller screen word address.
- `scr_data`  out  16  screen word at `scr_addr`, registered.
- `bad_access`  out  1  sticky flag: an access fell outside the map.

## Operation
- Address map, decoded on `addressM`:
  - RAM at 0x0000–0x3FFF (16384 words).
  - SCREEN at 0x4000–0x5FFF (8192 words, index = `addressM[12:0]`).
  - KBD at 0x6000.
  - Everything else, including 0x6001–0xFFFF, is out of range.
- Reads:
  - `inM` is the word at `addressM` with no clock delay, so the CPU computes with M in the same cycle.
  - A KBD read returns the FIFO head, or 0x0000 when the FIFO is empty.
  - An out-of-range read returns 0x0000.
- Writes (`writeM`=1 at the clock edge):
  - RAM and SCREEN store `outM`.
  - A write to KBD pops the FIFO head, whatever the value of `outM`. A pop on an empty FIFO is ignored.
  - An out-of-range write is dropped and sets `bad_access`.
- An out-of-range read sets `bad_access` only while `writeM`=1. Pure reads never set it, because the CPU drives `addressM` freely.
- Key FIFO:
  - A push occurs on `key_valid & key_ready`.
  - `key_ready` = FIFO not full and `reset` low.
  - A `key_code` of 0x0000 completes the handshake but is discarded, since 0 means "no key".
  - A push and a pop in the same cycle on a non-empty FIFO: count unchanged, head advances, new key appended at the tail.
  - A push and a pop in the same cycle on an empty FIFO: the pop is ignored and the push is stored.
  - Pointers wrap modulo `KBD_DEPTH`. The count ranges 0..`KBD_DEPTH`.
- Display port: `scr_data` ← SCREEN[`scr_addr`] on every rising edge. A simultaneous CPU write to the same word returns the old value (read-before-write).
- Reset, effective at the rising edge while `reset`=1:
  - Empties the FIFO.
  - Clears `bad_access` and `scr_data` to 0.
  - RAM and SCREEN contents are not cleared.
  - A write or push in a reset cycle is discarded.
  - A reset in the middle of a key burst drops every queued key.

## Timing
- `inM`: 0-cycle latency, combinational from `addressM`, RAM/SCREEN contents and the FIFO head.
- Write-to-read: a word written at edge N is visible on `inM` immediately after edge N.
- A key pushed at edge N appears on a KBD read after edge N. A pop at edge N shows the next key, or 0, after edge N.
- `key_ready`: combinational from the count and `reset`. The scanner holds `key_code` and `key_valid` until it sees `key_ready`=1 at a rising edge.
- `scr_data`: 1-cycle latency from `scr_addr`.
- Values after reset: `key_ready`=1 once `reset` is low; `scr_data`=0; `bad_access`=0; `inM` at KBD = 0.

## Test plan
- RAM: write 0x1234 to 0x0010, then read 0x0010 → `inM`=0x1234 in the cycle after the write edge. Write 0x5555 to 0x3FFF → reads back 0x5555, and 0x0010 is unchanged.
- Screen port: CPU writes 0xFFFF to 0x4000. Drive `scr_addr`=0 in the same cycle → `scr_data` shows the old value, then 0xFFFF one cycle later. Reading 0x4000 from the CPU → 0xFFFF.
- FIFO: push 0x0041, 0x0042, 0x0043, 0x0044 → `key_ready`=0. A fifth key is held off. KBD reads 0x0041. Write to 0x6000 → 0x0042, and `key_ready` returns to 1.
- FIFO edges:
  - With 3 keys queued, a simultaneous push of 0x0045 and a pop keeps the count at 3, and the head advances.
  - Pushing `key_code`=0 leaves the count unchanged.
  - Four pops drain the FIFO, after which KBD = 0. A further pop keeps it at 0.
- Out of range: writing 0x7000 with `writeM`=1 → `bad_access`=1 and stays 1. Reading 0x6001 → `inM`=0. A read of 0x8000 with `writeM`=0 on a fresh reset → `bad_access` stays 0.
- Reset mid-operation: with 2 keys queued and `bad_access`=1, a 1-cycle `reset` → KBD=0, `bad_access`=0, `scr_data`=0. RAM word 0x0010 still holds its value. A push attempted during reset is not stored.
